// File: rtl/e_bus_cycle_sequencer.sv
// ============================================================================
// Module  : e_bus_cycle_sequencer
// Brief   : Per-E-cycle chip-select / read / write strobe sequencer running
//           in the fast clock domain, with stretch and short-cycle flags.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module e_bus_cycle_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int SETUP_CYCLES    = 4,
    parameter int HOLD_CYCLES     = 2,
    parameter int MAX_HIGH_CYCLES = 100,
    parameter int CNT_W           = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_e_clk,
    input  logic i_rw,
    input  logic i_addr_hit,
    output logic o_cs,
    output logic o_rd,
    output logic o_wr,
    output logic o_data_latch,
    output logic o_busy,
    output logic o_e_stretch,
    output logic o_short_cycle
);

    localparam logic [CNT_W-1:0] c_SETUP     = CNT_W'(SETUP_CYCLES);
    localparam logic [CNT_W-1:0] c_MAX_HIGH  = CNT_W'(MAX_HIGH_CYCLES);
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_SAT   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SKIP   = 3'd1,
        S_SETUP  = 3'd2,
        S_ACTIVE = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_e_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hold_cnt;
    state_t                 r_state;
    logic                   r_rw_q;
    logic                   r_cs;
    logic                   r_rd;
    logic                   r_wr;
    logic                   r_data_latch;
    logic                   r_e_stretch;
    logic                   r_short_cycle;

    logic                   w_e_s;
    logic                   w_rise;
    logic                   w_fall;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic                   w_setup_done;
    logic                   w_max_hit;
    logic                   w_start;

    assign w_e_s     = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_e_s & ~r_e_prev;
    assign w_fall    = ~w_e_s & r_e_prev;
    assign w_cnt_inc = (r_cnt == c_CNT_SAT) ? r_cnt : r_cnt + 1'b1;

    // Thresholds test the value the counter is about to take, so the
    // registered strobe lands on the same edge the count reaches the limit.
    assign w_setup_done = w_e_s && (w_cnt_inc == c_SETUP);
    assign w_max_hit    = w_e_s && (w_cnt_inc == c_MAX_HIGH);
    assign w_start      = w_rise && ((r_state == S_IDLE) || (r_state == S_HOLD));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync   <= '0;
            r_e_prev <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_e_clk};
            r_e_prev <= w_e_s;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= '0;
        end else if (w_e_s) begin
            r_cnt <= w_cnt_inc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_rw_q        <= 1'b0;
            r_hold_cnt    <= '0;
            r_cs          <= 1'b0;
            r_rd          <= 1'b0;
            r_wr          <= 1'b0;
            r_data_latch  <= 1'b0;
            r_e_stretch   <= 1'b0;
            r_short_cycle <= 1'b0;
        end else begin
            r_data_latch <= 1'b0;
            if (w_start) begin
                // A new E cycle pre-empts any remaining chip-select hold.
                r_cs          <= 1'b0;
                r_rw_q        <= i_rw;
                r_e_stretch   <= 1'b0;
                r_short_cycle <= 1'b0;
                r_state       <= i_addr_hit ? S_SETUP : S_SKIP;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_SKIP: begin
                        if (w_fall) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_SETUP: begin
                        if (w_fall) begin
                            r_short_cycle <= 1'b1;
                            r_state       <= S_IDLE;
                        end else if (w_setup_done) begin
                            r_cs    <= 1'b1;
                            r_rd    <= r_rw_q;
                            r_wr    <= ~r_rw_q;
                            r_state <= S_ACTIVE;
                        end
                    end
                    S_ACTIVE: begin
                        if (w_fall) begin
                            r_rd         <= 1'b0;
                            r_wr         <= 1'b0;
                            r_data_latch <= ~r_rw_q;
                            r_hold_cnt   <= '0;
                            r_state      <= S_HOLD;
                        end else if (w_max_hit) begin
                            r_e_stretch <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (r_hold_cnt == c_HOLD_LAST) begin
                            r_cs    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_cs    <= 1'b0;
                        r_rd    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_cs          = r_cs;
    assign o_rd          = r_rd;
    assign o_wr          = r_wr;
    assign o_data_latch  = r_data_latch;
    assign o_busy        = (r_state != S_IDLE);
    assign o_e_stretch   = r_e_stretch;
    assign o_short_cycle = r_short_cycle;

endmodule

`default_nettype wire

// File: tb/tb_e_bus_cycle_sequencer.sv
// ============================================================================
// Module  : tb_e_bus_cycle_sequencer
// Brief   : Self-checking bench; expected waveforms are built from the
//           E-cycle timing rules (edge arithmetic per cycle) and compared.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_e_bus_cycle_sequencer;

    localparam int SYNC  = 2;
    localparam int SETUP = 4;
    localparam int HOLD  = 2;
    localparam int MAXH  = 100;
    localparam int CNTW  = 8;
    localparam int TMAX  = 4096;
    localparam int LEAD  = 3;

    logic clk = 1'b0;
    logic rst;
    logic e_clk;
    logic rw;
    logic hit;
    logic cs, rd, wr, dl, busy, stretch, short_c;

    always #5 clk = ~clk;

    e_bus_cycle_sequencer #(
        .SYNC_STAGES    (SYNC),
        .SETUP_CYCLES   (SETUP),
        .HOLD_CYCLES    (HOLD),
        .MAX_HIGH_CYCLES(MAXH),
        .CNT_W          (CNTW)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_e_clk      (e_clk),
        .i_rw         (rw),
        .i_addr_hit   (hit),
        .o_cs         (cs),
        .o_rd         (rd),
        .o_wr         (wr),
        .o_data_latch (dl),
        .o_busy       (busy),
        .o_e_stretch  (stretch),
        .o_short_cycle(short_c)
    );

    int total = 0;
    int bad   = 0;

    // E-cycle plan: high length / low length in fast clocks, R/W and hit.
    int p_hi[$];
    int p_lo[$];
    bit p_rw[$];
    bit p_hit[$];

    // Vector bit order: {cs, rd, wr, data_latch, busy, stretch, short}
    logic [6:0] exp_v [TMAX];
    logic [6:0] obs_v [TMAX];
    bit         e_at  [TMAX];
    bit         rw_at [TMAX];
    bit         hit_at[TMAX];
    int         n_edges;
    bit         prev_short;
    bit         prev_stretch;

    function automatic void add_seg(int h, int l, bit r, bit a);
        p_hi.push_back(h);
        p_lo.push_back(l);
        p_rw.push_back(r);
        p_hit.push_back(a);
    endfunction

    function automatic void clear_plan();
        p_hi.delete();
        p_lo.delete();
        p_rw.delete();
        p_hit.delete();
    endfunction

    function automatic void fill(int a, int b, int bn);
        for (int k = a; k < b && k <= n_edges; k++) exp_v[k][bn] = 1'b1;
    endfunction

    // Edge k is the k-th clock edge of the scenario; it samples e_at[k].
    // A cycle whose first high sample is edge r and first low sample edge f
    // is seen by the sequencer at r+SYNC (rise) and f+SYNC (fall).
    task automatic build_model();
        int r, f, rn, n;
        bit act;
        n_edges = LEAD + HOLD + SYNC + 6;
        foreach (p_hi[i]) n_edges += p_hi[i] + p_lo[i];
        for (int k = 0; k < TMAX; k++) begin
            exp_v[k]  = '0;
            e_at[k]   = 1'b0;
            rw_at[k]  = 1'($urandom_range(0, 1));
            hit_at[k] = 1'($urandom_range(0, 1));
        end
        r = LEAD + 1;
        for (int k = 1; k < r + SYNC; k++) begin
            exp_v[k][1] = prev_stretch;
            exp_v[k][0] = prev_short;
        end
        foreach (p_hi[i]) begin
            n  = p_hi[i];
            f  = r + n;
            rn = (i + 1 < p_hi.size()) ? f + p_lo[i] : n_edges + SYNC + 10;
            for (int k = r; k < f; k++) e_at[k] = 1'b1;
            rw_at[r + SYNC]  = p_rw[i];
            hit_at[r + SYNC] = p_hit[i];
            act = p_hit[i] && (n - 1 >= SETUP);
            fill(r + SYNC, act ? f + SYNC + HOLD : f + SYNC, 2);
            if (act) begin
                fill(r + SYNC + SETUP, (f + SYNC + HOLD < rn + SYNC) ? f + SYNC + HOLD : rn + SYNC, 6);
                fill(r + SYNC + SETUP, f + SYNC, p_rw[i] ? 5 : 4);
                if (!p_rw[i]) fill(f + SYNC, f + SYNC + 1, 3);
                if (n - 1 >= MAXH) fill(r + SYNC + MAXH, rn + SYNC, 1);
            end
            if (p_hit[i] && !act) fill(f + SYNC, rn + SYNC, 0);
            r = rn;
        end
        prev_stretch = exp_v[n_edges][1];
        prev_short   = exp_v[n_edges][0];
    endtask

    task automatic play();
        for (int k = 1; k <= n_edges; k++) begin
            @(negedge clk);
            e_clk = e_at[k];
            rw    = rw_at[k];
            hit   = hit_at[k];
            @(posedge clk);
            #1;
            obs_v[k] = {cs, rd, wr, dl, busy, stretch, short_c};
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        e_clk = 1'b0;
        rw    = 1'b0;
        hit   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e_clk = ~e_clk;
            @(posedge clk);
            #1;
            total++;
            if ({cs, rd, wr, dl, busy, stretch, short_c} !== 7'b0) begin
                bad++;
                $display("FAIL reset_hold clk%0d: got %b want 0000000", k, {cs, rd, wr, dl, busy, stretch, short_c});
            end
        end
        @(negedge clk);
        e_clk = 1'b0;
        rst   = 1'b0;
        repeat (SYNC + 3) @(posedge clk);
        #1;
        total++;
        if ({cs, rd, wr, dl, busy, stretch, short_c} !== 7'b0) begin
            bad++;
            $display("FAIL reset_release: got %b want 0000000", {cs, rd, wr, dl, busy, stretch, short_c});
        end
        prev_short   = 1'b0;
        prev_stretch = 1'b0;
    endtask

    task automatic test_read();
        int first_cs;
        clear_plan();
        add_seg(50, 50, 1'b1, 1'b1);
        build_model();
        play();
        for (int k = 1; k <= n_edges; k++) begin
            total++;
            if (obs_v[k] !== exp_v[k]) begin
                bad++;
                $display("FAIL read edge%0d: got %b want %b", k, obs_v[k], exp_v[k]);
            end
        end
        first_cs = 0;
        for (int k = n_edges; k >= 1; k--) if (obs_v[k][6]) first_cs = k;
        total++;
        if (first_cs !== LEAD + SYNC + SETUP + 1) begin
            bad++;
            $display("FAIL read_latency: got edge %0d want edge %0d", first_cs, LEAD + SYNC + SETUP + 1);
        end
    endtask

    task automatic test_write();
        int pulses;
        clear_plan();
        add_seg(50, 50, 1'b0, 1'b1);
        build_model();
        play();
        pulses = 0;
        for (int k = 1; k <= n_edges; k++) begin
            total++;
            if (obs_v[k] !== exp_v[k]) begin
                bad++;
                $display("FAIL write edge%0d: got %b want %b", k, obs_v[k], exp_v[k]);
            end
            if (obs_v[k][3] === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 1) begin
            bad++;
            $display("FAIL write_latch_count: got %0d want 1", pulses);
        end
    endtask

    task automatic test_no_hit();
        clear_plan();
        add_seg(50, 50, 1'b1, 1'b0);
        add_seg(30, 20, 1'b0, 1'b0);
        build_model();
        play();
        for (int k = 1; k <= n_edges; k++) begin
            total++;
            if (obs_v[k] !== exp_v[k]) begin
                bad++;
                $display("FAIL no_hit edge%0d: got %b want %b", k, obs_v[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_stretch();
        int first_st;
        clear_plan();
        add_seg(150, 50, 1'b1, 1'b1);
        add_seg(50, 30, 1'b0, 1'b1);
        build_model();
        play();
        first_st = 0;
        for (int k = 1; k <= n_edges; k++) begin
            total++;
            if (obs_v[k] !== exp_v[k]) begin
                bad++;
                $display("FAIL stretch edge%0d: got %b want %b", k, obs_v[k], exp_v[k]);
            end
        end
        for (int k = n_edges; k >= 1; k--) if (obs_v[k][1]) first_st = k;
        total++;
        if (first_st !== LEAD + 1 + SYNC + MAXH) begin
            bad++;
            $display("FAIL stretch_time: got edge %0d want edge %0d", first_st, LEAD + 1 + SYNC + MAXH);
        end
    endtask

    task automatic test_short();
        clear_plan();
        add_seg(4, 30, 1'b1, 1'b1);
        add_seg(SETUP, 10, 1'b0, 1'b1);
        add_seg(SETUP + 1, 20, 1'b0, 1'b1);
        add_seg(40, 30, 1'b1, 1'b1);
        build_model();
        play();
        for (int k = 1; k <= n_edges; k++) begin
            total++;
            if (obs_v[k] !== exp_v[k]) begin
                bad++;
                $display("FAIL short edge%0d: got %b want %b", k, obs_v[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_plan();
        for (int i = 0; i < 10; i++)
            add_seg($urandom_range(6, 12), $urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'b1);
        build_model();
        play();
        for (int k = 1; k <= n_edges; k++) begin
            total++;
            if (obs_v[k] !== exp_v[k]) begin
                bad++;
                $display("FAIL back_to_back edge%0d: got %b want %b", k, obs_v[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_random();
        clear_plan();
        for (int i = 0; i < 24; i++) begin
            if (i == 7 || i == 17)
                add_seg($urandom_range(MAXH - 2, MAXH + 20), $urandom_range(1, 20), 1'($urandom_range(0, 1)), 1'b1);
            else
                add_seg($urandom_range(1, 40), $urandom_range(1, 20), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        end
        build_model();
        play();
        for (int k = 1; k <= n_edges; k++) begin
            total++;
            if (obs_v[k] !== exp_v[k]) begin
                bad++;
                $display("FAIL random edge%0d: got %b want %b", k, obs_v[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        e_clk = 1'b1;
        rw    = 1'b0;
        hit   = 1'b1;
        repeat (SYNC + SETUP + 2) @(posedge clk);
        #1;
        total++;
        if ({cs, wr, busy} !== 3'b111) begin
            bad++;
            $display("FAIL mid_reset_pre: got cs/wr/busy %b want 111", {cs, wr, busy});
        end
        @(negedge clk);
        rst   = 1'b1;
        e_clk = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({cs, rd, wr, dl, busy, stretch, short_c} !== 7'b0) begin
            bad++;
            $display("FAIL mid_reset_drop: got %b want 0000000", {cs, rd, wr, dl, busy, stretch, short_c});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (SYNC + 4) @(posedge clk);
        #1;
        total++;
        if ({cs, rd, wr, dl, busy, stretch, short_c} !== 7'b0) begin
            bad++;
            $display("FAIL mid_reset_after: got %b want 0000000", {cs, rd, wr, dl, busy, stretch, short_c});
        end
        prev_short   = 1'b0;
        prev_stretch = 1'b0;
    endtask

    initial begin
        prev_short   = 1'b0;
        prev_stretch = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_no_hit();
        test_stretch();
        test_short();
        test_back_to_back();
        test_mid_reset();
        test_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
